// File: rtl/snake_move_ctrl_if.sv
// -----------------------------------------------------------------------------
// snake_move_ctrl_if
//   Bundles the four raw push-button lines and the move1 word/strobe produced
//   by snake_move_ctrl.
//
//   Signals:
//     btn_up, btn_down, btn_left, btn_right : raw buttons, asynchronous to clock
//     move1       [31:0] : {16'b0, press_cnt[7:0], 5'b0, dir[2:0]}
//     move_strobe        : one-cycle pulse on the edge where move1 updates
//
//   Modports:
//     master : button source / move1 consumer (board wrapper or testbench)
//     slave  : snake_move_ctrl itself
// -----------------------------------------------------------------------------
interface snake_move_ctrl_if;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic [31:0] move1;
    logic        move_strobe;

    modport master (
        output btn_up,
        output btn_down,
        output btn_left,
        output btn_right,
        input  move1,
        input  move_strobe
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        input  btn_left,
        input  btn_right,
        output move1,
        output move_strobe
    );
endinterface

// File: rtl/snake_move_ctrl.sv
// -----------------------------------------------------------------------------
// snake_move_ctrl
//   Front end for skeleton_proc: turns four raw board push-buttons into the
//   32-bit move1 word that software polls to steer the snake.
//   Each button is polarity-normalised, synchronised (2 flops), debounced and
//   rising-edge detected. Accepted presses update the held direction and an
//   8-bit wrapping press counter.
//
//   Ports:
//     clock : system clock, all state on the rising edge
//     reset : asynchronous, active-high reset
//     bus   : snake_move_ctrl_if.slave (buttons in, move1/move_strobe out)
//
//   Parameters:
//     DEBOUNCE_CYCLES : consecutive differing samples needed to accept a level
//                       change (>= 1)
//     CNT_W           : debounce counter width, must hold DEBOUNCE_CYCLES
//     BTN_ACTIVE_LOW  : 1 = buttons read 0 when pressed
//
//   Build option:
//     SNAKE_MOVE_NO_REVERSE_EN : when defined, a press opposite to the current
//                                direction (up<->down, left<->right) is
//                                rejected; from dir=0 everything is accepted.
//
//   Direction codes: 0 none, 1 up, 2 down, 3 left, 4 right.
//   Latency: a level held from before edge 1 flips the debounced level at edge
//   DEBOUNCE_CYCLES+2 and updates move1/move_strobe at edge DEBOUNCE_CYCLES+3.
// -----------------------------------------------------------------------------
module snake_move_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    snake_move_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    // Bit order doubles as priority order: bit 0 (up) wins.
    logic [3:0] btn_raw;
    logic [3:0] press_evt;
    logic [3:0] press_q;

    assign btn_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    // -------------------------------------------------------------------------
    // Per-button synchroniser + debouncer + rising-edge detector
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic             sync1_q;
            logic             sync2_q;
            logic             deb_q;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_inc;
            logic             flip;

            assign cnt_inc = cnt_q + CNT_W'(1);
            // The level change is accepted on the edge whose increment would
            // reach the limit, so the counter never actually holds the limit.
            assign flip    = (sync2_q != deb_q) && (cnt_inc == DEB_LIMIT);

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    deb_q   <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= btn_raw[gi] ^ BTN_ACTIVE_LOW;
                    sync2_q <= sync1_q;
                    if (sync2_q == deb_q) begin
                        // Any agreeing sample means the input bounced back.
                        cnt_q <= '0;
                    end else if (flip) begin
                        cnt_q <= '0;
                        deb_q <= ~deb_q;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
            end

            // Only released->pressed transitions are events.
            assign press_evt[gi] = flip && !deb_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Decision: pick one event by priority, optionally veto reversals
    // -------------------------------------------------------------------------
    logic [2:0] dir_q;
    logic [7:0] press_cnt_q;
    logic       strobe_q;
    logic [2:0] win_code_d;
    logic       accept_d;

    always_comb begin
        win_code_d = DIR_NONE;
        if (press_q[0])      win_code_d = DIR_UP;
        else if (press_q[1]) win_code_d = DIR_DOWN;
        else if (press_q[2]) win_code_d = DIR_LEFT;
        else if (press_q[3]) win_code_d = DIR_RIGHT;

        accept_d = (win_code_d != DIR_NONE);
`ifdef SNAKE_MOVE_NO_REVERSE_EN
        // Lower-priority events are already dropped, so a vetoed winner means
        // nothing is accepted this cycle.
        if (((dir_q == DIR_UP)    && (win_code_d == DIR_DOWN))  ||
            ((dir_q == DIR_DOWN)  && (win_code_d == DIR_UP))    ||
            ((dir_q == DIR_LEFT)  && (win_code_d == DIR_RIGHT)) ||
            ((dir_q == DIR_RIGHT) && (win_code_d == DIR_LEFT))) begin
            accept_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            press_q     <= 4'b0;
            dir_q       <= DIR_NONE;
            press_cnt_q <= 8'd0;
            strobe_q    <= 1'b0;
        end else begin
            press_q  <= press_evt;
            strobe_q <= accept_d;
            if (accept_d) begin
                dir_q       <= win_code_d;
                press_cnt_q <= press_cnt_q + 8'd1;
            end
        end
    end

    // Built purely from flops, so move1 is stable between strobes.
    assign bus.move1       = {16'b0, press_cnt_q, 5'b0, dir_q};
    assign bus.move_strobe = strobe_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snake_move_ctrl
//   Self-checking bench for snake_move_ctrl with DEBOUNCE_CYCLES=4,
//   BTN_ACTIVE_LOW=0. A reference model predicts move1/move_strobe from the
//   button history: a debounced level flips when the D samples seen by the
//   synchroniser output are all opposite to it; presses are resolved one
//   cycle later by priority. Compiles with or without SNAKE_MOVE_NO_REVERSE_EN.
// -----------------------------------------------------------------------------
module tb_snake_move_ctrl;

    localparam int D = 4;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    snake_move_ctrl_if bus();

    snake_move_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3),
        .BTN_ACTIVE_LOW  (1'b0)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    logic [63:0] hist [4];   // bit 0 = sample taken at the latest edge
    bit          mdeb [4];
    bit   [3:0]  pend;
    int          mdir;
    int          mcnt;
    bit          mstrobe;
    logic [31:0] exp_move1;
    logic        exp_strobe;

    always @(posedge clk or posedge rst) begin : model
        bit [3:0] raw;
        bit [3:0] newp;
        int       win;
        bit       all_diff;
        bit       veto;
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                hist[b] = '0;
                mdeb[b] = 1'b0;
            end
            pend    = '0;
            mdir    = 0;
            mcnt    = 0;
            mstrobe = 1'b0;
        end else begin
            // resolve presses detected on the previous edge
            win = 0;
            if (pend[0])      win = 1;
            else if (pend[1]) win = 2;
            else if (pend[2]) win = 3;
            else if (pend[3]) win = 4;
            veto = 1'b0;
`ifdef SNAKE_MOVE_NO_REVERSE_EN
            veto = (mdir == 1 && win == 2) || (mdir == 2 && win == 1) ||
                   (mdir == 3 && win == 4) || (mdir == 4 && win == 3);
`endif
            mstrobe = 1'b0;
            if (win != 0 && !veto) begin
                mdir    = win;
                mcnt    = (mcnt + 1) % 256;
                mstrobe = 1'b1;
            end
            // debounced levels: samples two..D+1 edges back are what the
            // synchroniser has delivered to the debouncer so far
            raw  = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
            newp = '0;
            for (int b = 0; b < 4; b++) begin
                hist[b]  = {hist[b][62:0], raw[b]};
                all_diff = 1'b1;
                for (int k = 2; k <= D + 1; k++)
                    if (hist[b][k] == mdeb[b]) all_diff = 1'b0;
                if (all_diff) begin
                    mdeb[b] = !mdeb[b];
                    if (mdeb[b]) newp[b] = 1'b1;
                end
            end
            pend = newp;
        end
        exp_move1  = {16'h0, 8'(mcnt), 5'b0, 3'(mdir)};
        exp_strobe = mstrobe;
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic set_btns(input bit u, input bit d, input bit l, input bit r);
        bus.btn_up    = u;
        bus.btn_down  = d;
        bus.btn_left  = l;
        bus.btn_right = r;
    endtask

    // Reset is released on a falling edge, so the next rising edge is edge 1.
    task automatic do_reset(input bit u, input bit d, input bit l, input bit r);
        set_btns(u, d, l, r);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_btns(0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.move1 !== 32'h0 || bus.move_strobe !== 1'b0) begin
            failures++;
            $display("FAIL reset_state move1=%h strobe=%b required move1=00000000 strobe=0",
                     bus.move1, bus.move_strobe);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.move1 !== 32'h0 || bus.move_strobe !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle move1=%h strobe=%b required move1=00000000 strobe=0",
                         bus.move1, bus.move_strobe);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_up_hold();
        do_reset(1, 0, 0, 0);
        for (int e = 1; e <= 57; e++) begin
            @(negedge clk);
            checks++;
            if (bus.move1 !== exp_move1 || bus.move_strobe !== exp_strobe) begin
                failures++;
                $display("FAIL up_hold_model edge=%0d move1=%h strobe=%b required %h/%b",
                         e, bus.move1, bus.move_strobe, exp_move1, exp_strobe);
            end
            if (e < 7) begin
                checks++;
                if (bus.move1 !== 32'h0) begin
                    failures++;
                    $display("FAIL up_hold_early edge=%0d move1=%h required 00000000", e, bus.move1);
                end
            end else begin
                checks++;
                if (bus.move1 !== 32'h0000_0101 || bus.move_strobe !== (e == 7)) begin
                    failures++;
                    $display("FAIL up_hold_value edge=%0d move1=%h strobe=%b required 00000101/%b",
                             e, bus.move1, bus.move_strobe, (e == 7));
                end
            end
        end
        $display("test_up_hold move1=%h", bus.move1);
    endtask

    task automatic test_midrun_reset();
        // still holding up from the previous test, move1 is 0x101
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.move1 !== 32'h0 || bus.move_strobe !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset_async move1=%h strobe=%b required 00000000/0",
                     bus.move1, bus.move_strobe);
        end
        @(negedge clk);
        rst = 1'b0;
        // button still held: fresh press after full latency
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            checks++;
            if (bus.move1 !== exp_move1 || bus.move_strobe !== exp_strobe ||
                bus.move1 !== ((e >= 7) ? 32'h0000_0101 : 32'h0)) begin
                failures++;
                $display("FAIL midrun_reset_repress edge=%0d move1=%h strobe=%b required %h/%b",
                         e, bus.move1, bus.move_strobe, exp_move1, exp_strobe);
            end
        end
        bus.btn_up = 1'b0;
        $display("test_midrun_reset move1=%h", bus.move1);
    endtask

    task automatic test_bounce();
        bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            bus.btn_left = pat[p];
            repeat (2) begin
                @(negedge clk);
                checks++;
                if (bus.move1 !== 32'h0 || bus.move_strobe !== 1'b0 || bus.move1 !== exp_move1) begin
                    failures++;
                    $display("FAIL bounce_quiet move1=%h strobe=%b required 00000000/0",
                             bus.move1, bus.move_strobe);
                end
            end
        end
        bus.btn_left = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            checks++;
            if (bus.move1 !== exp_move1 || bus.move_strobe !== exp_strobe ||
                bus.move1 !== ((e >= 7) ? 32'h0000_0103 : 32'h0) ||
                bus.move_strobe !== (e == 7)) begin
                failures++;
                $display("FAIL bounce_settle edge=%0d move1=%h strobe=%b required %h/%b",
                         e, bus.move1, bus.move_strobe, ((e >= 7) ? 32'h103 : 32'h0), (e == 7));
            end
        end
        bus.btn_left = 1'b0;
        $display("test_bounce move1=%h", bus.move1);
    endtask

    task automatic test_simultaneous();
        do_reset(0, 0, 0, 0);
        @(negedge clk);
        bus.btn_down  = 1'b1;
        bus.btn_right = 1'b1;
        for (int e = 1; e <= 27; e++) begin
            @(negedge clk);
            checks++;
            if (bus.move1 !== exp_move1 || bus.move_strobe !== exp_strobe ||
                bus.move1 !== ((e >= 7) ? 32'h0000_0102 : 32'h0) ||
                bus.move_strobe !== (e == 7)) begin
                failures++;
                $display("FAIL simultaneous edge=%0d move1=%h strobe=%b required %h/%b",
                         e, bus.move1, bus.move_strobe, ((e >= 7) ? 32'h102 : 32'h0), (e == 7));
            end
        end
        set_btns(0, 0, 0, 0);
        $display("test_simultaneous move1=%h", bus.move1);
    endtask

    task automatic test_reversal();
        int          strobes;
        logic [31:0] want;
        do_reset(0, 0, 0, 0);
        for (int ph = 0; ph < 4; ph++) begin
            bus.btn_up   = (ph == 0);
            bus.btn_down = (ph == 2);
            strobes = 0;
            repeat (10) begin
                @(negedge clk);
                if (bus.move_strobe === 1'b1) strobes++;
                checks++;
                if (bus.move1 !== exp_move1 || bus.move_strobe !== exp_strobe) begin
                    failures++;
                    $display("FAIL reversal_model phase=%0d move1=%h strobe=%b required %h/%b",
                             ph, bus.move1, bus.move_strobe, exp_move1, exp_strobe);
                end
            end
            if (ph == 2) begin
`ifdef SNAKE_MOVE_NO_REVERSE_EN
                want = 32'h0000_0101;
                checks++;
                if (strobes != 0 || bus.move1 !== want) begin
                    failures++;
                    $display("FAIL reversal_reject strobes=%0d move1=%h required 0/%h", strobes, bus.move1, want);
                end
`else
                want = 32'h0000_0202;
                checks++;
                if (strobes != 1 || bus.move1 !== want) begin
                    failures++;
                    $display("FAIL reversal_accept strobes=%0d move1=%h required 1/%h", strobes, bus.move1, want);
                end
`endif
            end
        end
        $display("test_reversal move1=%h", bus.move1);
    endtask

    task automatic test_wrap();
        do_reset(0, 0, 0, 0);
        for (int p = 0; p < 256; p++) begin
            for (int c = 0; c < 16; c++) begin
                bus.btn_right = (c < 8);
                @(negedge clk);
                checks++;
                if (bus.move1 !== exp_move1 || bus.move_strobe !== exp_strobe) begin
                    failures++;
                    $display("FAIL wrap_model press=%0d move1=%h strobe=%b required %h/%b",
                             p, bus.move1, bus.move_strobe, exp_move1, exp_strobe);
                end
            end
        end
        checks++;
        if (bus.move1 !== 32'h0000_0004) begin
            failures++;
            $display("FAIL wrap_final move1=%h required 00000004", bus.move1);
        end
        $display("test_wrap move1=%h", bus.move1);
    endtask

    task automatic test_random();
        bit [3:0] b;
        int       strobes;
        do_reset(0, 0, 0, 0);
        b = '0;
        strobes = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(7) == 0) b[i] = ~b[i];
            set_btns(b[0], b[1], b[2], b[3]);
            @(negedge clk);
            if (bus.move_strobe === 1'b1) strobes++;
            checks++;
            if (bus.move1 !== exp_move1 || bus.move_strobe !== exp_strobe) begin
                failures++;
                $display("FAIL random_model cycle=%0d move1=%h strobe=%b required %h/%b",
                         c, bus.move1, bus.move_strobe, exp_move1, exp_strobe);
            end
        end
        set_btns(0, 0, 0, 0);
        $display("test_random strobes=%0d move1=%h", strobes, bus.move1);
    endtask

    initial begin
        rst = 1'b1;
        set_btns(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_up_hold();
        test_midrun_reset();
        test_bounce();
        test_simultaneous();
        test_reversal();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
